// File: rtl/ad7991_pkg.sv
// rtl/ad7991_pkg.sv - shared types, defaults and word/channel helpers for the AD7991 responder
package ad7991_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_WR_BYTE  = 4'd3,
        ST_WR_ACK   = 4'd4,
        ST_RD_MSB   = 4'd5,
        ST_RD_LSB   = 4'd6,
        ST_RD_MACK  = 4'd7,
        ST_IGNORE   = 4'd8
    } state_t;

    localparam logic [6:0] AD7991_ADDR_DEFAULT = 7'h28;
    localparam logic [7:0] AD7991_CFG_DEFAULT  = 8'h10;
    localparam int         CH_SEL_LSB          = 4;

    function automatic logic [15:0] make_word(input logic [1:0] ch_id, input logic [11:0] data);
        return {2'b00, ch_id, data};
    endfunction

    // Next selected channel strictly after cur (wrapping); starting from 3 yields the lowest.
    function automatic logic [1:0] next_channel(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] c;
        logic [1:0] r;
        logic       found;
        r     = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            c = cur + 2'(i);
            if (!found && mask[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ad7991_i2c_responder_cond.sv
// rtl/ad7991_i2c_responder_cond.sv - I2C line synchronizer, glitch filter and bus event detector
module i2c_line_conditioner #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0]            r_scl_sync;
    logic [1:0]            r_sda_sync;
    logic [FILTER_LEN-1:0] r_scl_hist;
    logic [FILTER_LEN-1:0] r_sda_hist;
    logic                  r_scl_f;
    logic                  r_sda_f;
    logic                  r_scl_prev;
    logic                  r_sda_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_hist <= FILTER_LEN'({r_scl_hist, r_scl_sync[1]});
            r_sda_hist <= FILTER_LEN'({r_sda_hist, r_sda_sync[1]});
            // A level is accepted only once the whole history agrees.
            if (&r_scl_hist)       r_scl_f <= 1'b1;
            else if (~|r_scl_hist) r_scl_f <= 1'b0;
            if (&r_sda_hist)       r_sda_f <= 1'b1;
            else if (~|r_sda_hist) r_sda_f <= 1'b0;
            r_scl_prev <= r_scl_f;
            r_sda_prev <= r_sda_f;
        end
    end

    assign o_scl      = r_scl_f;
    assign o_sda      = r_sda_f;
    assign o_scl_rise = r_scl_f & ~r_scl_prev;
    assign o_scl_fall = ~r_scl_f & r_scl_prev;
    assign o_start    = r_scl_f & r_scl_prev & r_sda_prev & ~r_sda_f;
    assign o_stop     = r_scl_f & r_scl_prev & ~r_sda_prev & r_sda_f;

endmodule

// File: rtl/ad7991_i2c_responder.sv
// rtl/ad7991_i2c_responder.sv - I2C target emulating the AD7991 4-channel 12-bit ADC
module ad7991_i2c_responder
    import ad7991_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = AD7991_ADDR_DEFAULT,
    parameter logic [7:0] CFG_DEFAULT = AD7991_CFG_DEFAULT,
    parameter int         HOLD_CYCLES = 8,
    parameter int         FILTER_LEN  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    input  logic [11:0] ch2_data,
    input  logic [11:0] ch3_data,
    output logic [7:0]  cfg_reg,
    output logic        busy
);

    localparam logic [1:0] PTR_DEFAULT = next_channel(CFG_DEFAULT[CH_SEL_LSB +: 4], 2'd3);

    logic w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_line_conditioner #(.FILTER_LEN(FILTER_LEN)) u_cond (
        .clk       (clk),
        .reset     (reset),
        .i_scl     (scl_i),
        .i_sda     (sda_i),
        .o_scl     (w_scl_f),
        .o_sda     (w_sda_f),
        .o_scl_rise(w_scl_rise),
        .o_scl_fall(w_scl_fall),
        .o_start   (w_start),
        .o_stop    (w_stop)
    );

    state_t      r_state;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_cfg;
    logic [1:0]  r_ptr;
    logic [15:0] r_word;
    logic        r_after_lsb;
    logic        r_busy;
    logic        r_sda_oe;
    logic        r_hold_act;
    logic [7:0]  r_hold_cnt;

    logic [7:0]  w_byte;
    logic [1:0]  w_next_ptr;
    logic        w_oe_target;

    function automatic logic [11:0] sel_sample(input logic [1:0] idx, input logic [11:0] d0,
                                               input logic [11:0] d1, input logic [11:0] d2,
                                               input logic [11:0] d3);
        case (idx)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    assign w_byte     = {r_shift, w_sda_f};
    assign w_next_ptr = next_channel(r_cfg[CH_SEL_LSB +: 4], r_ptr);

    // Level SDA should take for the SCL-low phase that follows the current state/bit.
    always_comb begin
        w_oe_target = 1'b0;
        case (r_state)
            ST_ADDR_ACK, ST_WR_ACK: w_oe_target = 1'b1;
            ST_RD_MSB:              w_oe_target = ~r_word[{1'b1, ~r_bitcnt}];
            ST_RD_LSB:              w_oe_target = ~r_word[{1'b0, ~r_bitcnt}];
            default:                w_oe_target = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 7'd0;
            r_cfg       <= CFG_DEFAULT;
            r_ptr       <= PTR_DEFAULT;
            r_word      <= 16'd0;
            r_after_lsb <= 1'b0;
            r_busy      <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_hold_act  <= 1'b0;
            r_hold_cnt  <= 8'd0;
        end else begin
            if (w_scl_fall) begin
                r_hold_act <= 1'b1;
                r_hold_cnt <= 8'(HOLD_CYCLES - 1);
            end else if (r_hold_act) begin
                if (r_hold_cnt == 8'd0) begin
                    r_hold_act <= 1'b0;
                    if (!w_scl_f) r_sda_oe <= w_oe_target;
                end else begin
                    r_hold_cnt <= r_hold_cnt - 8'd1;
                end
            end

            if (w_stop) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_hold_act <= 1'b0;
            end else if (w_start) begin
                r_state    <= ST_ADDR;
                r_bitcnt   <= 3'd0;
                r_sda_oe   <= 1'b0;
                r_hold_act <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ST_ADDR, ST_WR_BYTE: begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (r_state == ST_WR_BYTE) begin
                                r_cfg   <= w_byte;
                                r_ptr   <= next_channel(w_byte[CH_SEL_LSB +: 4], 2'd3);
                                r_state <= ST_WR_ACK;
                            end else if (w_byte[7:1] == DEVICE_ADDR) begin
                                r_state <= ST_ADDR_ACK;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        r_bitcnt <= 3'd0;
                        if (r_shift[0]) begin
                            r_word      <= make_word(r_ptr, sel_sample(r_ptr, ch0_data, ch1_data, ch2_data, ch3_data));
                            r_after_lsb <= 1'b0;
                            r_state     <= ST_RD_MSB;
                        end else begin
                            r_state <= ST_WR_BYTE;
                        end
                    end
                    ST_WR_ACK: begin
                        r_bitcnt <= 3'd0;
                        r_state  <= ST_WR_BYTE;
                    end
                    ST_RD_MSB, ST_RD_LSB: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_after_lsb <= (r_state == ST_RD_LSB);
                            r_state     <= ST_RD_MACK;
                        end
                    end
                    ST_RD_MACK: begin
                        r_bitcnt <= 3'd0;
                        if (w_sda_f) begin
                            r_state <= ST_IGNORE;
                        end else if (r_after_lsb) begin
                            r_ptr       <= w_next_ptr;
                            r_word      <= make_word(w_next_ptr, sel_sample(w_next_ptr, ch0_data, ch1_data, ch2_data, ch3_data));
                            r_after_lsb <= 1'b0;
                            r_state     <= ST_RD_MSB;
                        end else begin
                            r_state <= ST_RD_LSB;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reset releases the bus combinationally so SDA is freed in the cycle reset is seen.
    assign sda_oe  = r_sda_oe & ~reset;
    assign cfg_reg = r_cfg;
    assign busy    = r_busy;

endmodule

// File: tb/tb_ad7991_i2c_responder.sv
// tb/tb_ad7991_i2c_responder.sv - self-checking bench for ad7991_i2c_responder
module tb_ad7991_i2c_responder;

    localparam int Q = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [11:0] ch0_data = 12'h0, ch1_data = 12'h0, ch2_data = 12'h0, ch3_data = 12'h0;
    logic        sda_oe, busy;
    logic [7:0]  cfg_reg;
    logic        sda_line;
    logic        oe_seen = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    assign sda_line = ~(m_sda_low | sda_oe);

    ad7991_i2c_responder dut (
        .clk     (clk),
        .reset   (reset),
        .scl_i   (scl),
        .sda_i   (sda_line),
        .sda_oe  (sda_oe),
        .ch0_data(ch0_data),
        .ch1_data(ch1_data),
        .ch2_data(ch2_data),
        .ch3_data(ch3_data),
        .cfg_reg (cfg_reg),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (sda_oe) oe_seen = 1'b1;

    typedef struct {
        logic [7:0]  cfg;
        logic [11:0] c0, c1, c2, c3;
        int          nbytes;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; tick(Q);
        scl = 1'b1;       tick(Q);
        m_sda_low = 1'b1; tick(Q);
        scl = 1'b0;       tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; tick(Q);
        scl = 1'b1;       tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; tick(Q);
        scl = 1'b1;     tick(2 * Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; tick(Q);
        scl = 1'b1;       tick(Q);
        b = sda_line;     tick(Q);
        scl = 1'b0;       tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(~ack);
    endtask

    task automatic write_cfg(input logic [7:0] cfg);
        logic ack;
        i2c_start();
        write_byte(8'h50, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd1);
        check("wr_busy_after_ack", {31'd0, busy}, 32'd1);
        write_byte(cfg, ack);
        check("wr_data_ack", {31'd0, ack}, 32'd1);
        check("wr_cfg_reg", {24'd0, cfg_reg}, {24'd0, cfg});
        i2c_stop();
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_seq(input int n, input logic [47:0] exp);
        logic ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h51, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i != n - 1);
            check("rd_byte", {24'd0, d}, {24'd0, exp[47 - 8 * i -: 8]});
        end
        check("rd_released_after_nack", {31'd0, sda_oe}, 32'd0);
        i2c_stop();
    endtask

    initial begin
        logic ack;
        logic b;
        logic [7:0] d;

        vecs[0] = '{8'h30, 12'h123, 12'hABC, 12'h000, 12'h000, 6, 48'h0123_1ABC_0123};
        vecs[1] = '{8'h00, 12'hFFF, 12'h000, 12'h000, 12'h000, 4, 48'h0FFF_0FFF_0000};
        vecs[2] = '{8'hF0, 12'h001, 12'h002, 12'h003, 12'h004, 6, 48'h0001_1002_2003};
        vecs[3] = '{8'h80, 12'h000, 12'h000, 12'h000, 12'hABC, 4, 48'h3ABC_3ABC_0000};
        vecs[4] = '{8'hA0, 12'h000, 12'h111, 12'h000, 12'h333, 6, 48'h1111_3333_1111};

        reset = 1'b1;
        tick(5);
        check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset_cfg", {24'd0, cfg_reg}, 32'h10);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(10);

        for (int v = 0; v < 5; v++) begin
            ch0_data = vecs[v].c0;
            ch1_data = vecs[v].c1;
            ch2_data = vecs[v].c2;
            ch3_data = vecs[v].c3;
            write_cfg(vecs[v].cfg);
            read_seq(vecs[v].nbytes, vecs[v].exp);
        end

        // Wrong address: no ACK, no drive, cfg untouched.
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h52, ack);
        check("nomatch_addr_ack", {31'd0, ack}, 32'd0);
        check("nomatch_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h77, ack);
        check("nomatch_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("nomatch_cfg", {24'd0, cfg_reg}, 32'hA0);
        check("nomatch_oe_seen", {31'd0, oe_seen}, 32'd0);
        check("nomatch_busy_end", {31'd0, busy}, 32'd0);

        // Sample changes in the middle of the MSB must not tear the word.
        ch2_data = 12'h555;
        write_cfg(8'h40);
        i2c_start();
        write_byte(8'h51, ack);
        check("tear_addr_ack", {31'd0, ack}, 32'd1);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
            if (i == 3) ch2_data = 12'hAAA;
        end
        write_bit(1'b0);
        check("tear_msb0", {24'd0, d}, 32'h25);
        read_byte(d, 1'b1);
        check("tear_lsb0", {24'd0, d}, 32'h55);
        read_byte(d, 1'b1);
        check("tear_msb1", {24'd0, d}, 32'h2A);
        read_byte(d, 1'b0);
        check("tear_lsb1", {24'd0, d}, 32'hAA);
        i2c_stop();

        // Repeated START mid-address, then reset while driving a 0 in the LSB.
        ch2_data = 12'h000;
        write_cfg(8'h40);
        i2c_start();
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_start();
        write_byte(8'h51, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(d, 1'b1);
        check("rs_msb", {24'd0, d}, 32'h20);
        read_bit(b);
        read_bit(b);
        check("rs_lsb_bit", {31'd0, b}, 32'd0);
        check("rs_lsb_driving", {31'd0, sda_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_release_same_cycle", {31'd0, sda_oe}, 32'd0);
        tick(2);
        check("midreset_cfg", {24'd0, cfg_reg}, 32'h10);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_sda_oe", {31'd0, sda_oe}, 32'd0);
        m_sda_low = 1'b0;
        scl = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);

        ch0_data = 12'h123;
        read_seq(2, 48'h0123_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
